// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: sync, debounce and left-turn request latching for the four vehicle detectors
// Optional stuck-detector fail-safe enabled by defining TL_STUCK_DET_EN.
module tl_sensor_cond #(
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 3,
    parameter int STUCK_CYCLES = 64,
    parameter int STUCK_W      = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_a,
    input  logic       raw_al,
    input  logic       raw_b,
    input  logic       raw_bl,
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    output logic       Ta,
    output logic       Tal,
    output logic       Tb,
    output logic       Tbl,
    output logic [3:0] fault
);
    localparam logic [1:0] LEFT = 2'b11;
    localparam logic [1:0] RED  = 2'b10;

    // channel order: 0=a, 1=al, 2=b, 3=bl
    logic [3:0]       raw, s1, s2, lvl, lvl_nxt;
    logic [CNT_W-1:0] cnt [4];
    logic [CNT_W-1:0] cnt_nxt [4];
    logic [1:0]       req, la_prev, lb_prev;
    logic             set_a, clr_a, set_b, clr_b;

    assign raw = {raw_bl, raw_b, raw_al, raw_a};

    // two-flop synchroniser per detector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // debounce: count edges where synced differs from accepted level, flip on the DEB_CYCLES-th
    always_comb begin
        lvl_nxt = lvl;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != lvl[i]) begin
                if (cnt[i] == CNT_W'(DEB_CYCLES - 1))
                    lvl_nxt[i] = ~lvl[i];
                else
                    cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    // debounce state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            lvl <= lvl_nxt;
            for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // left request set/clear terms; the set uses the level being accepted this edge
    always_comb begin
        set_a = lvl_nxt[1] && (La != LEFT);
        clr_a = (la_prev == LEFT) && (La != LEFT);
        set_b = lvl_nxt[3] && (Lb != LEFT);
        clr_b = (lb_prev == LEFT) && (Lb != LEFT);
    end

    // left request latches; end of a left phase wins over a new set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req     <= '0;
            la_prev <= RED;
            lb_prev <= RED;
        end else begin
            req[0]  <= clr_a ? 1'b0 : (set_a ? 1'b1 : req[0]);
            req[1]  <= clr_b ? 1'b0 : (set_b ? 1'b1 : req[1]);
            la_prev <= La;
            lb_prev <= Lb;
        end
    end

`ifdef TL_STUCK_DET_EN
    logic [STUCK_W-1:0] scnt [4];
    logic [3:0]         flt;

    // run-length of continuous presence per channel; fault is sticky once the limit is hit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flt <= '0;
            for (int i = 0; i < 4; i++) scnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                scnt[i] <= !lvl[i] ? '0 :
                           (scnt[i] == STUCK_W'(STUCK_CYCLES) ? scnt[i] : scnt[i] + 1'b1);
                flt[i]  <= flt[i] | (lvl[i] && scnt[i] == STUCK_W'(STUCK_CYCLES - 1));
            end
        end
    end

    assign fault = flt;
`else
    assign fault = 4'b0000;
`endif

    // a faulted channel keeps its output asserted so the approach keeps being served
    assign Ta  = lvl[0] | fault[0];
    assign Tal = req[0] | fault[1];
    assign Tb  = lvl[2] | fault[2];
    assign Tbl = req[1] | fault[3];
endmodule
